// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, widths and the field layout of a packed result entry.
package alu_pkg;

    localparam int RES_W = 4;
    localparam int OP_W  = 2;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_AND = 2'b10;
    localparam logic [OP_W-1:0] OP_OR  = 2'b11;

    // Packed entry layout {op, zero, cout, res} at default widths
    localparam int RES_LSB  = 0;
    localparam int COUT_BIT = 4;
    localparam int ZERO_BIT = 5;
    localparam int OP_LSB   = 6;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic show-ahead FIFO: head entry is visible on rd_data one cycle after it is written,
// rd_data reads as zero while empty, clr flushes synchronously with priority over push/pop.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Status comes from registered level only, so full never depends on the reader.
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push    = wr_en && !full && !clr;
    assign pop     = rd_en && !empty && !clr;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy separately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      level <= level + LVL_W'(1);
            else if (pop && !push) level <= level - LVL_W'(1);
        end
    end

endmodule

// File: rtl/alu_result_fifo.sv
// ALU result buffer: packs {op, zero, cout, res} into one word, queues it in a show-ahead
// FIFO, and tracks accepted results and dropped offers.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RES_W = alu_pkg::RES_W,
    parameter int OP_W  = alu_pkg::OP_W,
    localparam int DATA_W = OP_W + 2 + RES_W,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RES_W-1:0]  in_res,
    input  logic              in_cout,
    input  logic [OP_W-1:0]   in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic [7:0]        push_count
);

    logic              full;
    logic              empty;
    logic              push;
    logic [DATA_W-1:0] entry;

    // Zero flag is evaluated on the incoming result at push time.
    assign entry     = {in_op, (in_res == '0), in_cout, in_res};
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !clr;

    sync_fifo_fwft #(
        .WIDTH(DATA_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .wr_en  (in_valid),
        .wr_data(entry),
        .full   (full),
        .rd_en  (out_ready),
        .rd_data(out_data),
        .empty  (empty),
        .level  (level)
    );

    // Sticky drop flag and wrapping accept counter; clr wins over any same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            push_count <= '0;
        end else if (clr) begin
            overflow   <= 1'b0;
            push_count <= '0;
        end else begin
            if (in_valid && !in_ready) overflow <= 1'b1;
            if (push) push_count <= push_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: hand-computed expected words and levels.
module tb_alu_result_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_res;
    logic       in_cout;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] push_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_result_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_cout   (in_cout),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
        .push_count(push_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] r, input logic c, input logic [1:0] o);
        in_valid = v;
        in_res   = r;
        in_cout  = c;
        in_op    = o;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [3:0] r;

        rst_n = 1'b0; clr = 1'b0; out_ready = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 2'b00);
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_push_count", push_count, 0);
        rst_n = 1'b1;
        step();

        // first push: res=7 cout=0 op=00
        drive(1'b1, 4'h7, 1'b0, 2'b00);
        step();
        chk("p1_valid", out_valid, 1);
        chk("p1_data", out_data, 8'h07);
        chk("p1_level", level, 1);
        chk("p1_count", push_count, 1);

        // res=0 cout=1 op=01 -> 0111_0000 behind the head
        drive(1'b1, 4'h0, 1'b1, 2'b01);
        step();
        chk("p2_level", level, 2);
        chk("p2_head_held", out_data, 8'h07);
        drive(1'b0, 4'h0, 1'b0, 2'b00);
        out_ready = 1'b1;
        step();
        chk("p2_data_zero", out_data, 8'h70);
        chk("p2_level_pop", level, 1);
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_data", out_data, 0);

        // fill with res 1..4 op=10 while consumer stalls
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 1'b0, 2'b10);
            step();
        end
        chk("full_level", level, 4);
        chk("full_ready", in_ready, 0);
        chk("full_head", out_data, 8'h81);
        chk("full_count", push_count, 6);
        drive(1'b1, 4'h5, 1'b0, 2'b10);
        step();
        chk("ovf_set", overflow, 1);
        chk("ovf_count", push_count, 6);
        chk("ovf_level", level, 4);
        chk("ovf_head", out_data, 8'h81);

        // pop while full: offer is not admitted this cycle
        out_ready = 1'b1;
        drive(1'b1, 4'h6, 1'b0, 2'b10);
        step();
        chk("fpop_level", level, 3);
        chk("fpop_count", push_count, 6);
        chk("fpop_head", out_data, 8'h82);
        chk("fpop_ready", in_ready, 1);
        out_ready = 1'b0;
        step();
        chk("refill_level", level, 4);
        chk("refill_count", push_count, 7);

        // flush, then preload two entries for the streaming phase
        drive(1'b0, 4'h0, 1'b0, 2'b00);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr1_level", level, 0);
        chk("clr1_ovf", overflow, 0);
        chk("clr1_count", push_count, 0);
        drive(1'b1, 4'h8, 1'b1, 2'b11); step();
        drive(1'b1, 4'h9, 1'b1, 2'b11); step();
        exp_q = '{8'hD8, 8'hD9};
        chk("pre_level", level, 2);

        // push+pop every cycle; 8 more pushes wrap pointers past DEPTH
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = 4'(i + 10);
            drive(1'b1, r, 1'b1, 2'b11);
            chk("stream_head", out_data, exp_q[0]);
            step();
            void'(exp_q.pop_front());
            exp_q.push_back({2'b11, (r == 4'h0), 1'b1, r});
            chk("stream_level", level, 2);
        end
        chk("stream_tail_head", out_data, exp_q[0]);
        chk("stream_ovf", overflow, 0);
        chk("stream_count", push_count, 10);

        // get to level 3 with overflow set, then clr alongside a push offer
        out_ready = 1'b0;
        drive(1'b1, 4'h3, 1'b0, 2'b00); step(); step();
        step();
        chk("pre_clr_ovf", overflow, 1);
        drive(1'b0, 4'h0, 1'b0, 2'b00);
        out_ready = 1'b1;
        step();
        chk("pre_clr_level", level, 3);
        out_ready = 1'b0;
        drive(1'b1, 4'h1, 1'b0, 2'b00);
        clr = 1'b1;
        step();
        clr = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 2'b00);
        chk("clr2_level", level, 0);
        chk("clr2_valid", out_valid, 0);
        chk("clr2_ready", in_ready, 1);
        chk("clr2_ovf", overflow, 0);
        chk("clr2_count", push_count, 0);

        // asynchronous reset in the middle of a cycle
        drive(1'b1, 4'h2, 1'b0, 2'b01); step(); step();
        drive(1'b0, 4'h0, 1'b0, 2'b00);
        chk("mid_level", level, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_count", push_count, 0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 4'hA, 1'b0, 2'b01);
        step();
        drive(1'b0, 4'h0, 1'b0, 2'b00);
        chk("post_rst_data", out_data, 8'h4A);
        chk("post_rst_count", push_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
